// File: rtl/dfc_rr_sender.sv
// -----------------------------------------------------------------------------
// dfc_rr_sender
//
// Purpose:
//   Shares one delayed-flow-control (DFC) link among `inputs` srdy/drdy
//   requesters. Arbitration is round-robin and packet-aware: once a requester
//   starts a packet it keeps the grant until its EOP beat has transferred, so
//   packets from different requesters never interleave on the link. The link
//   side is a registered sender: p_vld/p_data/p_eop/p_src come straight from
//   flops, and beats are only launched while the receiver holds p_fc_n high.
//
// Parameters:
//   width   data bits per beat
//   inputs  number of requesters (2..16)
//   srcw    width of the source id, at least clog2(inputs)
//
// Ports:
//   clk      clock
//   reset    synchronous active-high reset
//   c_srdy   per-requester beat valid
//   c_drdy   per-requester beat accept (combinational, at most one bit set)
//   c_data   packed beats, requester i at [i*width +: width]
//   c_eop    per-requester end-of-packet flag for the presented beat
//   p_vld    registered link valid
//   p_fc_n   link flow control, 1 = may send, 0 = stop
//   p_data   registered link data
//   p_eop    registered EOP for the beat on p_data
//   p_src    registered index of the requester that sourced p_data
// -----------------------------------------------------------------------------
module dfc_rr_sender #(
  parameter int width  = 8,
  parameter int inputs = 4,
  parameter int srcw   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [inputs-1:0]         c_srdy,
  output logic [inputs-1:0]         c_drdy,
  input  logic [inputs*width-1:0]   c_data,
  input  logic [inputs-1:0]         c_eop,
  output logic                      p_vld,
  input  logic                      p_fc_n,
  output logic [width-1:0]          p_data,
  output logic                      p_eop,
  output logic [srcw-1:0]           p_src
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lockState_t;

  lockState_t        r_state;
  logic [srcw-1:0]   r_lockId;
  logic [srcw-1:0]   r_rrPtr;

  logic              r_pVld;
  logic [width-1:0]  r_pData;
  logic              r_pEop;
  logic [srcw-1:0]   r_pSrc;

  logic              w_found;
  logic [srcw-1:0]   w_sel;
  logic [srcw:0]     w_cand;
  logic              w_selSrdy;
  logic              w_selEop;
  logic [width-1:0]  w_selData;
  logic              w_xfer;

  // Selection. While a packet is in progress the owner is selected whether or
  // not it is currently asserting, which is what produces bubbles instead of
  // letting another requester slip in mid-packet. When idle, search starts one
  // past the last packet winner; the loop runs from the farthest candidate to
  // the nearest so the nearest asserting requester is written last and wins.
  // The candidate is kept one bit wider than the pointer so the wrap can be a
  // single compare-and-subtract instead of a modulo.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    if (r_state == ST_LOCKED) begin
      w_found = 1'b1;
      w_sel   = r_lockId;
    end else begin
      for (int k = inputs; k >= 1; k--) begin
        w_cand = {1'b0, r_rrPtr} + (srcw+1)'(k);
        if (w_cand >= (srcw+1)'(inputs)) begin
          w_cand = w_cand - (srcw+1)'(inputs);
        end
        if (c_srdy[w_cand[srcw-1:0]]) begin
          w_found = 1'b1;
          w_sel   = w_cand[srcw-1:0];
        end
      end
    end
  end

  // Fields of the selected requester's presented beat.
  always_comb begin
    w_selSrdy = c_srdy[w_sel];
    w_selEop  = c_eop[w_sel];
    w_selData = c_data[w_sel*width +: width];
  end

  // A beat moves only when the link is open, something is selected and the
  // selected requester really has a beat this cycle.
  assign w_xfer = p_fc_n & w_found & w_selSrdy;

  // Accept goes to the selected requester whenever the link is open, even if
  // that requester is not asserting srdy; requesters must not wait on it.
  always_comb begin
    c_drdy = '0;
    if (p_fc_n && w_found) begin
      c_drdy[w_sel] = 1'b1;
    end
  end

  // Output register and packet lock machine. The link outputs only change
  // on a transfer, except p_vld which follows the transfer every cycle. The
  // round-robin pointer moves only on an EOP transfer, so fairness is counted
  // in packets rather than beats. Reset abandons any partial packet silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_lockId <= '0;
      r_rrPtr  <= srcw'(inputs - 1);
      r_pVld   <= 1'b0;
      r_pData  <= '0;
      r_pEop   <= 1'b0;
      r_pSrc   <= '0;
    end else begin
      r_pVld <= w_xfer;
      if (w_xfer) begin
        r_pData <= w_selData;
        r_pEop  <= w_selEop;
        r_pSrc  <= w_sel;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_selEop) begin
              r_rrPtr <= w_sel;
            end else begin
              r_state  <= ST_LOCKED;
              r_lockId <= w_sel;
            end
          end
        end
        ST_LOCKED: begin
          if (w_xfer && w_selEop) begin
            r_state <= ST_IDLE;
            r_rrPtr <= r_lockId;
          end
        end
      endcase
    end
  end

  assign p_vld  = r_pVld;
  assign p_data = r_pData;
  assign p_eop  = r_pEop;
  assign p_src  = r_pSrc;

endmodule

// File: doc/dfc_rr_sender.md
Name: dfc_rr_sender

Overview:
- Round-robin, packet-aware arbiter that shares one delayed-flow-control (DFC) link between N srdy/drdy requesters.
- Each requester presents beats with an end-of-packet flag. Once a packet starts, the grant is held until its EOP beat transfers, so packets are never interleaved on the link.
- Output side is a registered DFC sender: p_vld/p_data are registered, and transmission is gated by the receiver's p_fc_n.
- Sits between on-chip srdy/drdy sources and a long, pipelined DFC channel.

Parameters:
- width, 8, data bits per beat
- inputs, 4, number of requesters (2..16)
- srcw, 2, width of source id; must be at least clog2(inputs)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- c_srdy  input  inputs  per-requester beat valid
- c_drdy  output  inputs  per-requester beat accept (combinational)
- c_data  input  inputs*width  packed beats; requester i occupies bits [i*width +: width]
- c_eop  input  inputs  per-requester end-of-packet flag for the presented beat
- p_vld  output  1  registered link valid
- p_fc_n  input  1  link flow control, active-low stop; 1 = may send
- p_data  output  width  registered link data
- p_eop  output  1  registered EOP for the beat on p_data
- p_src  output  srcw  registered index of the requester that sourced p_data

Behaviour:
- State registers:
  - rr_ptr: index of the last requester to complete a packet.
  - locked: 1 while a packet is in progress.
  - lock_id: requester owning the in-progress packet.
- Reset values: p_vld=0, p_data=0, p_eop=0, p_src=0, locked=0, lock_id=0, rr_ptr=inputs-1 (requester 0 has first priority).
- Selection (combinational):
  - If locked, sel=lock_id.
  - Otherwise, sel is the first i with c_srdy[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo inputs.
  - If no requester is asserting, there is no selection.
- xfer = p_fc_n & (a selection exists) & c_srdy[sel].
- c_drdy[i] = p_fc_n & (i == sel). At most one bit is set. It may be 1 while c_srdy[i]=0; requesters must not depend on c_drdy to assert c_srdy.
- Output register, every clock:
  - p_vld <= xfer.
  - On xfer: p_data <= beat of sel, p_eop <= c_eop[sel], p_src <= sel.
  - Without xfer, p_data/p_eop/p_src hold their previous values.
  - Latency from accepted input beat to p_vld is 1 cycle. Throughput is 1 beat/cycle while p_fc_n=1.
- Lock state machine, two states:
  - IDLE (locked=0):
    - xfer with c_eop[sel]=0 -> LOCKED, lock_id <= sel.
    - xfer with c_eop[sel]=1 (single-beat packet) -> stay IDLE, rr_ptr <= sel.
  - LOCKED (locked=1):
    - xfer with c_eop[lock_id]=1 -> IDLE, rr_ptr <= lock_id.
    - Otherwise stay LOCKED.
- rr_ptr updates only on EOP transfer. Fairness is therefore per packet, not per beat.
- Boundary cases:
  - Locked owner drops c_srdy mid-packet: bubble cycles (p_vld=0). The grant is not released, and other requesters stay blocked even if asserting.
  - p_fc_n=0: no xfer, all c_drdy=0, p_vld=0 next cycle, no state change. Receiver-side skid covers in-flight beats; this block adds no buffering.
  - p_fc_n rises: transfer resumes the same cycle from the held selection.
  - Only one requester active: it wins every packet back-to-back, with no idle cycle between packets.
  - rr_ptr=inputs-1: search wraps to 0.
  - Reset asserted mid-packet: all state returns to reset values. The partial packet is abandoned; no EOP is generated.
- Width rule: p_src is the zero-extended sel. Requesters with index >= inputs do not exist.

Test Plan:
- Single-beat fairness: inputs=4, all c_srdy=1, c_eop=1 every beat, p_fc_n=1 -> p_src sequence 0,1,2,3,0,1; p_vld=1 each cycle, starting 1 cycle after reset release.
- Packet lock: req0 sends a 3-beat packet (data 0x10,0x11,0x12, eop on the last), req1 requesting throughout -> p_data 0x10,0x11,0x12 with p_src=0, then req1's beats; c_drdy[1]=0 for the first 3 cycles.
- Owner bubble: req2 sends beat A (eop=0), drops c_srdy for 2 cycles, then sends B (eop=1); req3 requesting -> p_vld pattern 1,0,0,1; req3's first beat appears only after B.
- Flow control: stream from req1, p_fc_n=0 for 3 cycles mid-packet -> c_drdy all 0, p_vld=0 for exactly those 3 cycles (offset +1), no beat lost or duplicated, order preserved.
- Reset mid-packet: req0 locked after 2 of 4 beats, reset pulsed 1 cycle -> p_vld=0, p_src=0, p_data=0; next grant goes to the lowest-index requesting input (e.g. req1 if req0 is idle).
- Wrap/priority: rr_ptr=3 after req3 EOP, req0 and req2 requesting -> req0 wins, then req2.
